// File: rtl/alu_share_arbiter_if.sv
// alu_share_arbiter_if: requester/response handshakes and ALU hookup
// for the shared-ALU arbiter (slave = arbiter side, master = environment).
interface alu_share_arbiter_if #(
  parameter int DATA_W = 32,
  parameter int CTRL_W = 4
);
  logic              req0_valid;
  logic              req0_ready;
  logic [CTRL_W-1:0] req0_op;
  logic [DATA_W-1:0] req0_a;
  logic [DATA_W-1:0] req0_b;
  logic              req1_valid;
  logic              req1_ready;
  logic [CTRL_W-1:0] req1_op;
  logic [DATA_W-1:0] req1_a;
  logic [DATA_W-1:0] req1_b;

  logic              rsp0_valid;
  logic              rsp0_ready;
  logic [DATA_W-1:0] rsp0_result;
  logic              rsp0_zero;
  logic              rsp0_err;
  logic              rsp1_valid;
  logic              rsp1_ready;
  logic [DATA_W-1:0] rsp1_result;
  logic              rsp1_zero;
  logic              rsp1_err;

  logic [CTRL_W-1:0] alu_ctrl;
  logic [DATA_W-1:0] alu_src_a;
  logic [DATA_W-1:0] alu_src_b;
  logic [DATA_W-1:0] alu_result;
  logic              alu_zero;

  modport slave (
    input  req0_valid, req0_op, req0_a, req0_b,
    input  req1_valid, req1_op, req1_a, req1_b,
    input  rsp0_ready, rsp1_ready,
    input  alu_result, alu_zero,
    output req0_ready, req1_ready,
    output rsp0_valid, rsp0_result, rsp0_zero, rsp0_err,
    output rsp1_valid, rsp1_result, rsp1_zero, rsp1_err,
    output alu_ctrl, alu_src_a, alu_src_b
  );

  modport master (
    output req0_valid, req0_op, req0_a, req0_b,
    output req1_valid, req1_op, req1_a, req1_b,
    output rsp0_ready, rsp1_ready,
    output alu_result, alu_zero,
    input  req0_ready, req1_ready,
    input  rsp0_valid, rsp0_result, rsp0_zero, rsp0_err,
    input  rsp1_valid, rsp1_result, rsp1_zero, rsp1_err,
    input  alu_ctrl, alu_src_a, alu_src_b
  );
endinterface

// File: rtl/alu_share_arbiter.sv
// alu_share_arbiter: two requesters share one combinational ALU.
// Define ALU_ARB_FIXED_PRIO_EN for fixed port-0 priority instead of round-robin.
module alu_share_arbiter #(
  parameter int DATA_W = 32,
  parameter int CTRL_W = 4
) (
  input logic                clk,
  input logic                reset,
  alu_share_arbiter_if.slave bus
);

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    EXEC = 2'd1,
    RESP = 2'd2
  } state_t;

  state_t            state;
  logic              owner;
  logic              err_q;
  logic [CTRL_W-1:0] ctrl_q;
  logic [DATA_W-1:0] src_a_q;
  logic [DATA_W-1:0] src_b_q;

  logic [1:0]        rsp_valid;
  logic [1:0]        rsp_zero;
  logic [1:0]        rsp_err;
  logic [DATA_W-1:0] rsp_result [2];

`ifndef ALU_ARB_FIXED_PRIO_EN
  logic              rr_last;
`endif

  logic              grant0;
  logic              grant1;
  logic              accept;
  logic              sel;
  logic              sel_legal;
  logic              rsp_take;
  logic              both;
  logic [CTRL_W-1:0] sel_op;
  logic [DATA_W-1:0] sel_a;
  logic [DATA_W-1:0] sel_b;

  function automatic logic op_legal(
    input logic [CTRL_W-1:0] op
  );
    return (op <= CTRL_W'(8)) &&
           (op != CTRL_W'(3));
  endfunction

  assign both = bus.req0_valid &
                bus.req1_valid;

  // Grants only exist in IDLE and never while reset is held
  always_comb begin
    grant0 = 1'b0;
    grant1 = 1'b0;
    if (state == IDLE && !reset) begin
      unique case (1'b1)
        both: begin
`ifdef ALU_ARB_FIXED_PRIO_EN
          grant0 = 1'b1;
`else
          grant0 = rr_last;
          grant1 = !rr_last;
`endif
        end
        bus.req0_valid && !bus.req1_valid:
          grant0 = 1'b1;
        bus.req1_valid && !bus.req0_valid:
          grant1 = 1'b1;
        default: ;
      endcase
    end
  end

  assign accept    = grant0 | grant1;
  assign sel       = grant1;
  assign sel_op    = sel ? bus.req1_op : bus.req0_op;
  assign sel_a     = sel ? bus.req1_a  : bus.req0_a;
  assign sel_b     = sel ? bus.req1_b  : bus.req0_b;
  assign sel_legal = op_legal(sel_op);
  assign rsp_take  = owner ? bus.rsp1_ready
                           : bus.rsp0_ready;

  always_ff @(posedge clk) begin
    if (reset) begin
      state         <= IDLE;
      owner         <= 1'b0;
      err_q         <= 1'b0;
      ctrl_q        <= '0;
      src_a_q       <= '0;
      src_b_q       <= '0;
      rsp_valid     <= '0;
      rsp_zero      <= '0;
      rsp_err       <= '0;
      rsp_result[0] <= '0;
      rsp_result[1] <= '0;
`ifndef ALU_ARB_FIXED_PRIO_EN
      rr_last       <= 1'b1;
`endif
    end else begin
      unique case (state)
        IDLE: begin
          if (accept) begin
            owner   <= sel;
`ifndef ALU_ARB_FIXED_PRIO_EN
            rr_last <= sel;
`endif
            // Illegal codes run as a harmless AND; result is overridden
            err_q   <= !sel_legal;
            ctrl_q  <= sel_legal ? sel_op : '0;
            src_a_q <= sel_a;
            src_b_q <= sel_b;
            state   <= EXEC;
          end
        end
        EXEC: begin
          rsp_valid[owner]  <= 1'b1;
          rsp_result[owner] <= err_q ? '0
                                     : bus.alu_result;
          rsp_zero[owner]   <= err_q | bus.alu_zero;
          rsp_err[owner]    <= err_q;
          state             <= RESP;
        end
        RESP: begin
          if (rsp_take) begin
            rsp_valid[owner]  <= 1'b0;
            rsp_result[owner] <= '0;
            rsp_zero[owner]   <= 1'b0;
            rsp_err[owner]    <= 1'b0;
            state             <= IDLE;
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

  assign bus.req0_ready  = grant0;
  assign bus.req1_ready  = grant1;

  assign bus.rsp0_valid  = rsp_valid[0];
  assign bus.rsp0_result = rsp_result[0];
  assign bus.rsp0_zero   = rsp_zero[0];
  assign bus.rsp0_err    = rsp_err[0];
  assign bus.rsp1_valid  = rsp_valid[1];
  assign bus.rsp1_result = rsp_result[1];
  assign bus.rsp1_zero   = rsp_zero[1];
  assign bus.rsp1_err    = rsp_err[1];

  assign bus.alu_ctrl    = ctrl_q;
  assign bus.alu_src_a   = src_a_q;
  assign bus.alu_src_b   = src_b_q;

endmodule
